// File: rtl/alu_rs_scheduler.sv
// Reservation station for the integer ALU: holds dispatched ops until both operands
// are valid, snoops the ALU/LSB CDBs, and issues the lowest-index ready op per cycle.
module alu_rs_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             clear,
    input  logic             disp_valid,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [XLEN-1:0]  disp_vj,
    input  logic [XLEN-1:0]  disp_vk,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic             disp_qj_busy,
    input  logic             disp_qk_busy,
    input  logic [XLEN-1:0]  disp_a,
    input  logic [XLEN-1:0]  disp_pc,
    input  logic [ROB_W-1:0] disp_reorder,
    output logic             full,
    input  logic             cdb_alu_s,
    input  logic [ROB_W-1:0] cdb_alu_tag,
    input  logic [XLEN-1:0]  cdb_alu_val,
    input  logic             cdb_lsb_s,
    input  logic [ROB_W-1:0] cdb_lsb_tag,
    input  logic [XLEN-1:0]  cdb_lsb_val,
    output logic             alu_s,
    output logic [OP_W-1:0]  alu_op,
    output logic [XLEN-1:0]  alu_vj,
    output logic [XLEN-1:0]  alu_vk,
    output logic [ROB_W-1:0] alu_reorder,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_pc
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [ROB_W-1:0] qj;
        logic [ROB_W-1:0] qk;
        logic             qj_busy;
        logic             qk_busy;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] reorder;
    } entry_t;

    entry_t             ent [RS_SIZE];
    entry_t             sel_ent;
    entry_t             disp_ent;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               issue_any;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   free_idx;

    // Returns {still_pending, value}; ALU CDB is checked before LSB CDB.
    function automatic logic [XLEN:0] snoop(input logic pend, input logic [ROB_W-1:0] q,
                                            input logic [XLEN-1:0] v);
        if (pend && cdb_alu_s && q == cdb_alu_tag)      return {1'b0, cdb_alu_val};
        else if (pend && cdb_lsb_s && q == cdb_lsb_tag) return {1'b0, cdb_lsb_val};
        else                                            return {pend, v};
    endfunction

    // Scan high-to-low so the lowest matching index is the one left standing.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        issue_any = 1'b0;
        issue_idx = '0;
        free_idx  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && !ent[i].qj_busy && !ent[i].qk_busy;
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                issue_any = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!busy_vec[i]) free_idx = IDX_W'(i);
        end
    end

    assign full    = &busy_vec;
    assign sel_ent = ent[issue_idx];

    // Dispatch bypass: a tag broadcast in the dispatch cycle lands as already valid.
    always_comb begin
        disp_ent                       = '0;
        disp_ent.busy                  = 1'b1;
        disp_ent.op                    = disp_op;
        disp_ent.qj                    = disp_qj;
        disp_ent.qk                    = disp_qk;
        disp_ent.a                     = disp_a;
        disp_ent.pc                    = disp_pc;
        disp_ent.reorder               = disp_reorder;
        {disp_ent.qj_busy, disp_ent.vj} = snoop(disp_qj_busy, disp_qj, disp_vj);
        {disp_ent.qk_busy, disp_ent.vk} = snoop(disp_qk_busy, disp_qk, disp_vk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            alu_s       <= 1'b0;
            alu_op      <= '0;
            alu_vj      <= '0;
            alu_vk      <= '0;
            alu_reorder <= '0;
            alu_a       <= '0;
            alu_pc      <= '0;
        end else if (rdy) begin
            if (clear) begin
                for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
                alu_s       <= 1'b0;
                alu_op      <= '0;
                alu_vj      <= '0;
                alu_vk      <= '0;
                alu_reorder <= '0;
                alu_a       <= '0;
                alu_pc      <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent[i].busy) begin
                        {ent[i].qj_busy, ent[i].vj} <= snoop(ent[i].qj_busy, ent[i].qj, ent[i].vj);
                        {ent[i].qk_busy, ent[i].vk} <= snoop(ent[i].qk_busy, ent[i].qk, ent[i].vk);
                    end
                    if (issue_any && issue_idx == IDX_W'(i)) ent[i].busy <= 1'b0;
                end
                // free_idx is a non-busy slot, so it never collides with the issuing entry.
                if (disp_valid && !full) ent[free_idx] <= disp_ent;
                alu_s       <= issue_any;
                alu_op      <= issue_any ? sel_ent.op      : '0;
                alu_vj      <= issue_any ? sel_ent.vj      : '0;
                alu_vk      <= issue_any ? sel_ent.vk      : '0;
                alu_reorder <= issue_any ? sel_ent.reorder : '0;
                alu_a       <= issue_any ? sel_ent.a       : '0;
                alu_pc      <= issue_any ? sel_ent.pc      : '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios plus a randomized run
// compared against a slot-array reference model stepped once per clock edge.
module tb_alu_rs_scheduler;
    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clear = 1'b0;
    logic        disp_valid = 1'b0, disp_qj_busy = 1'b0, disp_qk_busy = 1'b0;
    logic [5:0]  disp_op = '0;
    logic [31:0] disp_vj = '0, disp_vk = '0, disp_a = '0, disp_pc = '0;
    logic [3:0]  disp_qj = '0, disp_qk = '0, disp_reorder = '0;
    logic        cdb_alu_s = 1'b0, cdb_lsb_s = 1'b0;
    logic [3:0]  cdb_alu_tag = '0, cdb_lsb_tag = '0;
    logic [31:0] cdb_alu_val = '0, cdb_lsb_val = '0;
    logic        full, alu_s;
    logic [5:0]  alu_op;
    logic [31:0] alu_vj, alu_vk, alu_a, alu_pc;
    logic [3:0]  alu_reorder;

    int checks = 0, failures = 0;

    alu_rs_scheduler dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_qj_busy(disp_qj_busy),
        .disp_qk_busy(disp_qk_busy), .disp_a(disp_a), .disp_pc(disp_pc),
        .disp_reorder(disp_reorder), .full(full),
        .cdb_alu_s(cdb_alu_s), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_s(cdb_lsb_s), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
        .alu_s(alu_s), .alu_op(alu_op), .alu_vj(alu_vj), .alu_vk(alu_vk),
        .alu_reorder(alu_reorder), .alu_a(alu_a), .alu_pc(alu_pc)
    );

    always #5 clk = ~clk;

    // Reference model: one slot per station entry, plain arrays.
    bit          m_busy [16];
    bit          m_jb [16], m_kb [16];
    logic [5:0]  m_op [16];
    logic [31:0] m_vj [16], m_vk [16], m_a [16], m_pc [16];
    logic [3:0]  m_qj [16], m_qk [16], m_ro [16];
    logic        e_s;
    logic [5:0]  e_op;
    logic [31:0] e_vj, e_vk, e_a, e_pc;
    logic [3:0]  e_ro;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        e_s = 0; e_op = '0; e_vj = '0; e_vk = '0; e_a = '0; e_pc = '0; e_ro = '0;
    endtask

    function automatic bit m_full();
        foreach (m_busy[i]) if (!m_busy[i]) return 0;
        return 1;
    endfunction

    task automatic resolve(inout bit pend, input logic [3:0] q, inout logic [31:0] v);
        if (pend && cdb_alu_s && q == cdb_alu_tag) begin pend = 0; v = cdb_alu_val; end
        else if (pend && cdb_lsb_s && q == cdb_lsb_tag) begin pend = 0; v = cdb_lsb_val; end
    endtask

    task automatic model_step();
        int sel = -1, fr = -1;
        bit was_full;
        if (!rdy) return;
        if (clear) begin model_reset(); return; end
        was_full = m_full();
        for (int i = 0; i < 16; i++) begin
            if (sel < 0 && m_busy[i] && !m_jb[i] && !m_kb[i]) sel = i;
            if (fr < 0 && !m_busy[i]) fr = i;
        end
        if (sel >= 0) begin
            e_s = 1; e_op = m_op[sel]; e_vj = m_vj[sel]; e_vk = m_vk[sel];
            e_ro = m_ro[sel]; e_a = m_a[sel]; e_pc = m_pc[sel];
        end else begin
            e_s = 0; e_op = '0; e_vj = '0; e_vk = '0; e_ro = '0; e_a = '0; e_pc = '0;
        end
        for (int i = 0; i < 16; i++) if (m_busy[i]) begin
            resolve(m_jb[i], m_qj[i], m_vj[i]);
            resolve(m_kb[i], m_qk[i], m_vk[i]);
        end
        if (sel >= 0) m_busy[sel] = 0;
        if (disp_valid && !was_full) begin
            m_busy[fr] = 1; m_op[fr] = disp_op; m_a[fr] = disp_a; m_pc[fr] = disp_pc;
            m_ro[fr] = disp_reorder; m_qj[fr] = disp_qj; m_qk[fr] = disp_qk;
            m_jb[fr] = disp_qj_busy; m_vj[fr] = disp_vj; m_kb[fr] = disp_qk_busy; m_vk[fr] = disp_vk;
            resolve(m_jb[fr], m_qj[fr], m_vj[fr]);
            resolve(m_kb[fr], m_qk[fr], m_vk[fr]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; cdb_alu_s = 0; cdb_lsb_s = 0; clear = 0; rdy = 1;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] vj, vk,
                            input logic [3:0] qj, input bit qjb, input logic [3:0] qk,
                            input bit qkb, input logic [3:0] ro);
        disp_valid = 1; disp_op = op; disp_vj = vj; disp_vk = vk; disp_qj = qj;
        disp_qj_busy = qjb; disp_qk = qk; disp_qk_busy = qkb; disp_reorder = ro;
        disp_a = 32'h100 + 32'(ro); disp_pc = 32'h4000 + 32'(ro) * 4;
    endtask

    task automatic flush();
        idle(); clear = 1; tick(); clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; model_reset(); #2;
        checks++; if (alu_s !== 1'b0) begin failures++; $display("FAIL reset_alu_s got=%0d exp=0", alu_s); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0d exp=0", full); end
        checks++; if ({alu_op, alu_vj, alu_vk, alu_reorder, alu_a, alu_pc} !== '0) begin
            failures++; $display("FAIL reset_alu_fields got=%h exp=0", {alu_op, alu_vj, alu_vk, alu_reorder});
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_basic_issue();
        set_disp(6'h01, 32'd5, 32'd7, 4'd0, 0, 4'd0, 0, 4'd9);
        tick(); idle();
        checks++; if (alu_s !== 1'b0) begin failures++; $display("FAIL basic_early got=%0d exp=0", alu_s); end
        tick();
        checks++; if ({alu_s, alu_op, alu_vj, alu_vk, alu_reorder} !== {1'b1, 6'h01, 32'd5, 32'd7, 4'd9}) begin
            failures++; $display("FAIL basic_issue got s=%0d op=%h vj=%0d vk=%0d ro=%0d exp 1/01/5/7/9",
                                 alu_s, alu_op, alu_vj, alu_vk, alu_reorder);
        end
        tick();
        checks++; if (alu_s !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%0d exp=0", alu_s); end
    endtask

    task automatic test_lsb_wakeup();
        set_disp(6'h02, 32'd0, 32'd1, 4'd3, 1, 4'd0, 0, 4'd4);
        tick(); idle(); tick();
        checks++; if (alu_s !== 1'b0) begin failures++; $display("FAIL wake_wait got=%0d exp=0", alu_s); end
        cdb_lsb_s = 1; cdb_lsb_tag = 4'd3; cdb_lsb_val = 32'hDEAD;
        tick(); idle();
        checks++; if (alu_s !== 1'b0) begin failures++; $display("FAIL wake_early got=%0d exp=0", alu_s); end
        tick();
        checks++; if (alu_s !== 1'b1 || alu_vj !== 32'hDEAD) begin
            failures++; $display("FAIL wake_issue got s=%0d vj=%h exp s=1 vj=dead", alu_s, alu_vj);
        end
    endtask

    task automatic test_bypass();
        set_disp(6'h03, 32'd11, 32'd0, 4'd0, 0, 4'd2, 1, 4'd6);
        cdb_alu_s = 1; cdb_alu_tag = 4'd2; cdb_alu_val = 32'h1234;
        tick(); idle(); tick();
        checks++; if (alu_s !== 1'b1 || alu_vk !== 32'h1234 || alu_reorder !== 4'd6) begin
            failures++; $display("FAIL bypass got s=%0d vk=%h ro=%0d exp s=1 vk=1234 ro=6", alu_s, alu_vk, alu_reorder);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            set_disp(6'(i), 32'd0, 32'd0, (i == 0) ? 4'd5 : 4'd6, 1, 4'd0, 0, 4'(i));
            tick();
        end
        idle();
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_set got=%0d exp=1", full); end
        set_disp(6'h3F, 32'd1, 32'd1, 4'd0, 0, 4'd0, 0, 4'd15);
        tick(); idle(); tick();
        checks++; if (full !== 1'b1 || alu_s !== 1'b0) begin
            failures++; $display("FAIL full_ignore got full=%0d s=%0d exp full=1 s=0", full, alu_s);
        end
        cdb_alu_s = 1; cdb_alu_tag = 4'd5; cdb_alu_val = 32'h55;
        tick(); idle(); tick();
        checks++; if (alu_s !== 1'b1 || alu_reorder !== 4'd0 || alu_vj !== 32'h55) begin
            failures++; $display("FAIL full_entry0 got s=%0d ro=%0d vj=%h exp 1/0/55", alu_s, alu_reorder, alu_vj);
        end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_release got=%0d exp=0", full); end
        flush();
    endtask

    task automatic test_priority();
        for (int i = 0; i < 5; i++) begin
            set_disp(6'h10, 32'(i), 32'd0, (i == 1 || i == 4) ? 4'd8 : 4'd7, 1, 4'd0, 0, 4'(i));
            tick();
        end
        idle(); cdb_lsb_s = 1; cdb_lsb_tag = 4'd8; cdb_lsb_val = 32'h88;
        tick(); idle(); tick();
        checks++; if (alu_s !== 1'b1 || alu_reorder !== 4'd1) begin
            failures++; $display("FAIL prio_first got s=%0d ro=%0d exp s=1 ro=1", alu_s, alu_reorder);
        end
        tick();
        checks++; if (alu_s !== 1'b1 || alu_reorder !== 4'd4) begin
            failures++; $display("FAIL prio_second got s=%0d ro=%0d exp s=1 ro=4", alu_s, alu_reorder);
        end
        tick();
        checks++; if (alu_s !== 1'b0) begin failures++; $display("FAIL prio_done got=%0d exp=0", alu_s); end
        flush();
    endtask

    task automatic test_clear_reset();
        for (int i = 0; i < 3; i++) begin
            set_disp(6'h20, 32'd0, 32'd0, 4'd7, 1, 4'd0, 0, 4'(i));
            tick();
        end
        set_disp(6'h21, 32'd1, 32'd2, 4'd0, 0, 4'd0, 0, 4'd3);
        clear = 1; tick(); idle();
        checks++; if (alu_s !== 1'b0 || full !== 1'b0) begin
            failures++; $display("FAIL clear_state got s=%0d full=%0d exp 0/0", alu_s, full);
        end
        cdb_alu_s = 1; cdb_alu_tag = 4'd7; tick(); idle(); tick();
        checks++; if (alu_s !== 1'b0) begin failures++; $display("FAIL clear_dropped got=%0d exp=0", alu_s); end
        set_disp(6'h22, 32'h77, 32'd0, 4'd0, 0, 4'd0, 0, 4'd2);
        tick(); idle(); tick();
        checks++; if (alu_s !== 1'b1) begin failures++; $display("FAIL pre_reset_issue got=%0d exp=1", alu_s); end
        #2; rst_n = 0; #1;
        checks++; if (alu_s !== 1'b0 || alu_vj !== 32'd0) begin
            failures++; $display("FAIL async_reset got s=%0d vj=%h exp 0/0", alu_s, alu_vj);
        end
        model_reset();
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(7) != 0);
            clear = ($urandom_range(49) == 0);
            disp_valid = ($urandom_range(9) < 6);
            disp_op = 6'($urandom); disp_vj = $urandom; disp_vk = $urandom;
            disp_qj = 4'($urandom); disp_qk = 4'($urandom);
            disp_qj_busy = ($urandom_range(2) != 0); disp_qk_busy = ($urandom_range(2) == 0);
            disp_a = $urandom; disp_pc = $urandom; disp_reorder = 4'($urandom);
            cdb_alu_s = ($urandom_range(9) < 4); cdb_alu_tag = 4'($urandom); cdb_alu_val = $urandom;
            cdb_lsb_s = ($urandom_range(9) < 4); cdb_lsb_tag = 4'($urandom); cdb_lsb_val = $urandom;
            if (cdb_alu_s && cdb_lsb_s && cdb_alu_tag == cdb_lsb_tag) cdb_lsb_tag = cdb_alu_tag + 4'd1;
            tick();
            checks++;
            if ({alu_s, alu_op, alu_vj, alu_vk, alu_reorder, alu_a, alu_pc} !==
                {e_s, e_op, e_vj, e_vk, e_ro, e_a, e_pc}) begin
                failures++;
                $display("FAIL rand_issue cyc=%0d got s=%0d op=%h vj=%h vk=%h ro=%0d exp s=%0d op=%h vj=%h vk=%h ro=%0d",
                         c, alu_s, alu_op, alu_vj, alu_vk, alu_reorder, e_s, e_op, e_vj, e_vk, e_ro);
            end
            checks++;
            if (full !== m_full()) begin
                failures++; $display("FAIL rand_full cyc=%0d got=%0d exp=%0d", c, full, m_full());
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_issue();
        test_lsb_wakeup();
        test_bypass();
        test_full();
        test_priority();
        test_clear_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
